// File: rtl/pipe_pkg.sv
// Shared widths, field offsets and bubble constants for the pipeline boundary registers.
// ID/EX is the first stage that uses them; later stages supply their own widths.
package pipe_pkg;

  localparam int ID_EX_CTRL_W = 11;
  localparam int ID_EX_DATA_W = 143;

  // ID/EX control bundle, MSB first: RegWrite .. RegDst, then ALUControl[3:0]
  localparam int CTRL_REGWRITE_BIT     = 10;
  localparam int CTRL_MEMTOREG_BIT     = 9;
  localparam int CTRL_MEMWRITE_BIT     = 8;
  localparam int CTRL_BRANCH_BIT       = 7;
  localparam int CTRL_ALUSRC_BIT       = 6;
  localparam int CTRL_ALUSRC_SHAMT_BIT = 5;
  localparam int CTRL_REGDST_BIT       = 4;
  localparam int CTRL_ALUCONTROL_MSB   = 3;
  localparam int CTRL_ALUCONTROL_LSB   = 0;

  localparam int DATA_RD1_MSB     = 142;
  localparam int DATA_RD1_LSB     = 111;
  localparam int DATA_RD2_MSB     = 110;
  localparam int DATA_RD2_LSB     = 79;
  localparam int DATA_SIGNIMM_MSB = 78;
  localparam int DATA_SIGNIMM_LSB = 47;
  localparam int DATA_PCPLUS4_MSB = 46;
  localparam int DATA_PCPLUS4_LSB = 15;
  localparam int DATA_RT_MSB      = 14;
  localparam int DATA_RT_LSB      = 10;
  localparam int DATA_RD_MSB      = 9;
  localparam int DATA_RD_LSB      = 5;
  localparam int DATA_SHAMT_MSB   = 4;
  localparam int DATA_SHAMT_LSB   = 0;

  localparam logic [ID_EX_CTRL_W-1:0] ID_EX_CTRL_BUBBLE = '0;
  localparam logic [ID_EX_DATA_W-1:0] ID_EX_DATA_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream bundle of a pipeline boundary register.
// valid/ready: a transfer happens on a rising edge where both valid and ready are 1;
// valid must not depend on ready, and the payload is only meaningful while valid is 1.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  // Pipeline control side: feeds entries in and applies stall/flush
  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  // The stage register itself
  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

endinterface

// File: rtl/pipe_slot.sv
// One v/ctrl/data storage slot. Reset zeroes everything; clear makes a bubble
// (v and ctrl zero) while the data bits hold; load captures a valid entry.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] d_ctrl_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic              v_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              v_q,    v_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    v_d    = v_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (clear_i) begin
      v_d    = 1'b0;
      ctrl_d = '0;
    end else if (load_i) begin
      v_d    = 1'b1;
      ctrl_d = d_ctrl_i;
      data_d = d_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q    <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign v_o    = v_q;
  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: main slot M drives the outputs, optional skid slot S
// absorbs one entry under stall so in_ready can come straight from a flop.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W,
  parameter bit SKID   = 1'b1
) (
  input  logic           CLK,
  input  logic           RST,
  pipe_stage_reg_if.slave bus
);

  logic              m_v;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              s_v;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;

  logic              in_ready_w;
  logic              in_fire;
  logic              m_upd;
  logic              m_load;
  logic              m_clear;
  logic              m_v_d;
  logic              s_v_d;
  logic [CTRL_W-1:0] m_d_ctrl;
  logic [DATA_W-1:0] m_d_data;
  logic [1:0]        occ_q, occ_d;

  assign in_fire = bus.in_valid & in_ready_w;
  assign m_upd   = !m_v | bus.out_ready;

  // M refills from S before it ever looks at the input, which keeps FIFO order
  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    if (bus.flush) begin
      m_clear = 1'b1;
    end else if (m_upd) begin
      if (s_v || in_fire) m_load  = 1'b1;
      else                m_clear = 1'b1;
    end
  end

  assign m_d_ctrl = s_v ? s_ctrl : bus.in_ctrl;
  assign m_d_data = s_v ? s_data : bus.in_data;
  assign m_v_d    = m_load | (m_v & !m_clear);

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_m_slot (
    .clk_i    (CLK),
    .rst_i    (RST),
    .load_i   (m_load),
    .clear_i  (m_clear),
    .d_ctrl_i (m_d_ctrl),
    .d_data_i (m_d_data),
    .v_o      (m_v),
    .ctrl_o   (m_ctrl),
    .data_o   (m_data)
  );

  generate
    if (SKID) begin : g_skid
      logic s_load;
      logic s_clear;

      always_comb begin
        s_load  = 1'b0;
        s_clear = 1'b0;
        if (bus.flush) begin
          s_clear = 1'b1;
        end else if (m_upd && s_v) begin
          s_clear = 1'b1;
        end else if (!m_upd && in_fire) begin
          s_load = 1'b1;
        end
      end

      assign s_v_d      = s_load | (s_v & !s_clear);
      // S full is the only thing that blocks input, so ready is a flop output
      assign in_ready_w = !s_v;

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_s_slot (
        .clk_i    (CLK),
        .rst_i    (RST),
        .load_i   (s_load),
        .clear_i  (s_clear),
        .d_ctrl_i (bus.in_ctrl),
        .d_data_i (bus.in_data),
        .v_o      (s_v),
        .ctrl_o   (s_ctrl),
        .data_o   (s_data)
      );
    end else begin : g_noskid
      assign s_v        = 1'b0;
      assign s_ctrl     = '0;
      assign s_data     = '0;
      assign s_v_d      = 1'b0;
      assign in_ready_w = !m_v | bus.out_ready;
    end
  endgenerate

  assign occ_d = {1'b0, m_v_d} + {1'b0, s_v_d};

  always_ff @(posedge CLK) begin
    if (RST) occ_q <= 2'd0;
    else     occ_q <= occ_d;
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = m_v;
  assign bus.out_ctrl  = m_ctrl;
  assign bus.out_data  = m_data;
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid-buffered instance and a single-register
// instance share clock and reset; expected values are hand-derived per step.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = ID_EX_CTRL_W;
  localparam int DW = ID_EX_DATA_W;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus1 ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus0 ();

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) dut1 (
    .CLK (clk),
    .RST (rst),
    .bus (bus1.slave)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) dut0 (
    .CLK (clk),
    .RST (rst),
    .bus (bus0.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive1(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    bus1.in_valid = v;
    bus1.in_ctrl  = c;
    bus1.in_data  = d;
  endtask

  task automatic drive0(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    bus0.in_valid = v;
    bus0.in_ctrl  = c;
    bus0.in_data  = d;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] ctl(input int n);
    return 11'h400 | CW'(n);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus1.flush = 1'b0; bus1.out_ready = 1'b0; drive1(1'b0, '0, '0);
    bus0.flush = 1'b0; bus0.out_ready = 1'b0; drive0(1'b0, '0, '0);
    tick();
    tick();
    chk("rst_valid",  bus1.out_valid, 0);
    chk("rst_ctrl",   bus1.out_ctrl,  0);
    chk("rst_data",   bus1.out_data,  0);
    chk("rst_occ",    bus1.occupancy, 0);
    chk("rst_valid0", bus0.out_valid, 0);
    rst = 1'b0;
    settle();
    chk("rst_ready",  bus1.in_ready,  1);

    // streaming 1..5 with out_ready held high
    bus1.out_ready = 1'b1;
    drive1(1'b1, ctl(1), DW'(1));
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("stream_data",  bus1.out_data,  n);
      chk("stream_ctrl",  bus1.out_ctrl,  ctl(n));
      chk("stream_valid", bus1.out_valid, 1);
      chk("stream_ready", bus1.in_ready,  1);
      chk("stream_occ",   bus1.occupancy, 1);
      if (n < 5) drive1(1'b1, ctl(n + 1), DW'(n + 1));
      else       drive1(1'b0, '0, '0);
    end

    // bubbles: ctrl zeroed, data holds the last entry
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("bubble_valid", bus1.out_valid, 0);
      chk("bubble_ctrl",  bus1.out_ctrl,  0);
      chk("bubble_data",  bus1.out_data,  5);
      chk("bubble_occ",   bus1.occupancy, 0);
    end

    // stall: A in M, B into S, C refused until drain
    drive1(1'b1, ctl('hA), DW'('hA));
    tick();
    bus1.out_ready = 1'b0;
    drive1(1'b1, ctl('hB), DW'('hB));
    settle();
    chk("stall_ready_b", bus1.in_ready, 1);
    tick();
    chk("stall_occ1",    bus1.occupancy, 2);
    chk("stall_ready0",  bus1.in_ready,  0);
    chk("stall_hold_a",  bus1.out_data,  'hA);
    drive1(1'b1, ctl('hC), DW'('hC));
    tick();
    chk("stall_occ2",    bus1.occupancy, 2);
    chk("stall_hold_a2", bus1.out_data,  'hA);
    bus1.out_ready = 1'b1;
    tick();
    chk("drain_b",       bus1.out_data,  'hB);
    chk("drain_b_ctrl",  bus1.out_ctrl,  ctl('hB));
    chk("drain_occ_b",   bus1.occupancy, 1);
    chk("drain_ready",   bus1.in_ready,  1);
    tick();
    chk("drain_c",       bus1.out_data,  'hC);
    chk("drain_occ_c",   bus1.occupancy, 1);
    drive1(1'b0, '0, '0);
    tick();
    chk("drain_empty",   bus1.out_valid, 0);

    // flush while full and stalled
    drive1(1'b1, ctl('hD), DW'('hD));
    tick();
    bus1.out_ready = 1'b0;
    drive1(1'b1, ctl('hE), DW'('hE));
    tick();
    chk("flush_pre_occ", bus1.occupancy, 2);
    bus1.flush = 1'b1;
    drive1(1'b1, 11'h7FF, DW'('hF));
    tick();
    bus1.flush = 1'b0;
    drive1(1'b0, '0, '0);
    chk("flush_valid", bus1.out_valid, 0);
    chk("flush_ctrl",  bus1.out_ctrl,  0);
    chk("flush_occ",   bus1.occupancy, 0);
    chk("flush_ready", bus1.in_ready,  1);
    chk("flush_data",  bus1.out_data,  'hD);

    // flush with ready high: accepted input is dropped
    bus1.out_ready = 1'b1;
    bus1.flush = 1'b1;
    drive1(1'b1, 11'h7FF, DW'('h77));
    settle();
    chk("flush2_ready", bus1.in_ready, 1);
    tick();
    bus1.flush = 1'b0;
    drive1(1'b0, '0, '0);
    chk("flush2_valid", bus1.out_valid, 0);
    chk("flush2_ctrl",  bus1.out_ctrl,  0);
    chk("flush2_data",  bus1.out_data,  'hD);
    tick();
    chk("flush2_never", bus1.out_valid, 0);
    chk("flush2_occ",   bus1.occupancy, 0);

    // reset mid-stall with two entries held
    drive1(1'b1, ctl('h10), DW'('h10));
    tick();
    bus1.out_ready = 1'b0;
    drive1(1'b1, ctl('h11), DW'('h11));
    tick();
    chk("rst2_pre_occ", bus1.occupancy, 2);
    rst = 1'b1;
    drive1(1'b0, '0, '0);
    tick();
    rst = 1'b0;
    chk("rst2_valid", bus1.out_valid, 0);
    chk("rst2_ctrl",  bus1.out_ctrl,  0);
    chk("rst2_data",  bus1.out_data,  0);
    chk("rst2_occ",   bus1.occupancy, 0);
    chk("rst2_ready", bus1.in_ready,  1);
    bus1.out_ready = 1'b1;
    drive1(1'b1, ctl(9), DW'(9));
    tick();
    drive1(1'b0, '0, '0);
    chk("rst2_first_data",  bus1.out_data,  9);
    chk("rst2_first_valid", bus1.out_valid, 1);

    // single-register variant: combinational ready
    bus0.out_ready = 1'b1;
    drive0(1'b1, ctl('h21), DW'('h21));
    settle();
    chk("ns_ready_empty", bus0.in_ready, 1);
    tick();
    chk("ns_data_21", bus0.out_data,  'h21);
    chk("ns_occ_21",  bus0.occupancy, 1);
    bus0.out_ready = 1'b0;
    drive0(1'b1, ctl('h22), DW'('h22));
    settle();
    chk("ns_ready_stall", bus0.in_ready, 0);
    tick();
    chk("ns_hold_21", bus0.out_data,  'h21);
    chk("ns_occ_max", bus0.occupancy, 1);
    bus0.out_ready = 1'b1;
    settle();
    chk("ns_ready_comb", bus0.in_ready, 1);
    tick();
    chk("ns_data_22", bus0.out_data, 'h22);
    drive0(1'b1, ctl('h23), DW'('h23));
    tick();
    chk("ns_b2b_data",  bus0.out_data,  'h23);
    chk("ns_b2b_valid", bus0.out_valid, 1);
    chk("ns_b2b_ctrl",  bus0.out_ctrl,  ctl('h23));
    drive0(1'b0, '0, '0);
    tick();
    chk("ns_bubble_valid", bus0.out_valid, 0);
    chk("ns_bubble_ctrl",  bus0.out_ctrl,  0);
    chk("ns_bubble_data",  bus0.out_data,  'h23);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
